cplx_reg_bank_p: RTL
====================

// Module: cplx_reg_bank_p
// PURPOSE
//  Parametrised complex-word register bank for the datapath. Each word is {re[W-1:0], im[W-1:0]}, with re in the upper half.
//  It has one write port with half-word enables and swap, and two registered read ports. Each read port can also load fixed constants {0,+1,-1}.
//  A built-in clear sequencer zeroes every entry after reset or on request, and raises busy while it runs.
// PARAMETERS
//  W      16  bits per half-word (re or im), two's complement fixed point
//  FRAC   14  fractional bits; +1 constant = 1<<FRAC, -1 = -(1<<FRAC); FRAC <= W-2
//  DEPTH  16  number of entries, power of 2, 2..256; AW = $clog2(DEPTH), SELW = max(AW,4)
// PORTS
//  clock    in   1       master clock, posedge
//  reset    in   1       synchronous, active-high
//  clr_req  in   1       pulse: start clear sequence (ignored while busy)
//  busy     out  1       1 while the clear sequencer runs
//  regwen   in   1       write enable
//  inA      in   2W      write data {re,im}
//  selwreg  in   AW      write index
//  endreg   in   2       00 both halves; 01 im only; 10 re only; 11 write {inA.im,inA.re} (swapped)
//  seloutA  in   SELW    read index, or constant code when cnstA=1
//  seloutB  in   SELW    as seloutA, for port B
//  cnstA    in   1       1: load constant instead of entry
//  cnstB    in   1       as cnstA
//  enrregA  in   1       load outA
//  enrregB  in   1       load outB
//  outA     out  2W      registered output A
//  outB     out  2W      registered output B
// BEHAVIOUR
//  - Reset (sync): outA=outB=0; FSM->CLEAR; clear pointer=0; busy=1 from the next cycle. Reset mid-clear restarts at entry 0.
//  - FSM IDLE: busy=0. clr_req=1 -> CLEAR, pointer=0.
//  - FSM CLEAR: one entry zeroed per cycle (entry[ptr]<=0, ptr++). After entry DEPTH-1 -> IDLE.
//    busy is high for exactly DEPTH cycles.
//  - While busy: regwen ignored; enrregX with cnstX=0 ignored (outX holds).
//    enrregX with cnstX=1 still loads the constant. clr_req ignored.
//  - Write (IDLE, regwen=1): entry[selwreg] updated at the clock edge per endreg; unselected halves keep their old value.
//  - Read latency is 1 cycle: enrregX=1 -> outX at the next edge. enrregX=0 -> outX holds.
//    Reads return the pre-write contents unless the bypass feature is compiled in.
//  - Constant code: seloutX[3:2] selects re, seloutX[1:0] selects im: 00->0, 01->+1, 10->-1, 11->0.
//    Bits of seloutX above bit 3 are ignored in constant mode.
//  - Index mode: only seloutX[AW-1:0] is used. When DEPTH<16 the upper bits are ignored, so the index wraps modulo DEPTH.
//  - Both ports may read the same entry in the same cycle; each gets an identical value.
//  - No arithmetic beyond constant generation. Constants are sign-correct W-bit values.
// CONFIGURATION
//  REG_BANK_BYPASS_EN defined: the write-to-read bypass is compiled in.
//    Condition: IDLE, regwen=1, enrregX=1, cnstX=0 and seloutX[AW-1:0]==selwreg.
//    outX gets the merged post-write word: halves selected by endreg come from inA (swapped if 11), the rest from the old entry.
//  REG_BANK_BYPASS_EN undefined: outX gets the old entry contents; the new value is visible on the following read.
// TESTING  (W=16, FRAC=14, DEPTH=16: +1=16'h4000, -1=16'hC000)
//  1 reset 1 cycle -> busy=1 for 16 cycles, then busy=0; read all 16 entries -> every outA=0.
//  2 write entry 3 = 32'h1111_2222 (endreg=00); next cycle endreg=01 inA=32'hAAAA_BBBB; read 3 -> 32'h1111_BBBB.
//    Then endreg=11 inA=32'h1234_5678; read -> 32'h5678_1234.
//  3 cnstA=1 seloutA=4'h6 -> outA=32'h4000_C000. cnstB=1 seloutB=4'h9 -> outB=32'hC000_4000. Code 4'hF -> 0.
//  4 same cycle: write entry 5 = 32'hDEAD_BEEF over 32'h0; enrregA=1 seloutA=5.
//    _EN defined -> outA=32'hDEAD_BEEF; undefined -> outA=0.
//  5 clr_req during IDLE with entries loaded -> busy for 16 cycles. regwen during busy is dropped.
//    Constant read during busy works. All entries read 0 afterwards.
//  6 reset asserted at clear-cycle 7 -> busy stays 1, sequence restarts and completes 16 cycles after reset release.

Source files
------------

// File: rtl/cplx_reg_bank_p.sv
// Complex-word register bank: one half-word-masked write port, two registered read
// ports with constant load, and a clear sequencer. Optional write-to-read bypass: REG_BANK_BYPASS_EN.
module cplx_reg_bank_p #(
  parameter int W     = 16,
  parameter int FRAC  = 14,
  parameter int DEPTH = 16,
  localparam int AW   = $clog2(DEPTH),
  localparam int SELW = (AW > 4) ? AW : 4
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            clr_req,
  output logic            busy,
  input  logic            regwen,
  input  logic [2*W-1:0]  inA,
  input  logic [AW-1:0]   selwreg,
  input  logic [1:0]      endreg,
  input  logic [SELW-1:0] seloutA,
  input  logic [SELW-1:0] seloutB,
  input  logic            cnstA,
  input  logic            cnstB,
  input  logic            enrregA,
  input  logic            enrregB,
  output logic [2*W-1:0]  outA,
  output logic [2*W-1:0]  outB
);

  // Handshake: none. Every input is sampled on each rising clock edge; a port
  // with enrregX=1 presents its new value one cycle later, otherwise it holds.

  typedef enum logic {IDLE = 1'b0, CLEAR = 1'b1} state_t;

  localparam logic [W-1:0] POS_ONE = W'(1) << FRAC;
  localparam logic [W-1:0] NEG_ONE = -POS_ONE;

  state_t            state;
  state_t            state_next;
  logic [AW-1:0]     ptr;
  logic [2*W-1:0]    mem [DEPTH];
  logic [2*W-1:0]    wr_old;
  logic [2*W-1:0]    wr_word;
  logic [AW-1:0]     idx_a;
  logic [AW-1:0]     idx_b;
  logic [2*W-1:0]    rd_a;
  logic [2*W-1:0]    rd_b;
  logic [2*W-1:0]    cnst_word_a;
  logic [2*W-1:0]    cnst_word_b;

  function automatic logic [W-1:0] cnst_half(input logic [1:0] code);
    case (code)
      2'b01:   cnst_half = POS_ONE;
      2'b10:   cnst_half = NEG_ONE;
      default: cnst_half = '0;
    endcase
  endfunction

  assign busy = (state == CLEAR);

  always_ff @(posedge clock) begin
    if (reset) begin
      state <= CLEAR;
      ptr   <= '0;
    end else begin
      state <= state_next;
      ptr   <= (state == CLEAR) ? ptr + AW'(1) : '0;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (clr_req) state_next = CLEAR;
      CLEAR:   if (ptr == AW'(DEPTH - 1)) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Merged post-write word: unselected halves keep the old entry contents.
  always_comb begin
    wr_old = mem[selwreg];
    case (endreg)
      2'b00:   wr_word = inA;
      2'b01:   wr_word = {wr_old[2*W-1:W], inA[W-1:0]};
      2'b10:   wr_word = {inA[2*W-1:W], wr_old[W-1:0]};
      default: wr_word = {inA[W-1:0], inA[2*W-1:W]};
    endcase
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      if (state == CLEAR)
        mem[ptr] <= '0;
      else if (regwen)
        mem[selwreg] <= wr_word;
    end
  end

  assign idx_a       = seloutA[AW-1:0];
  assign idx_b       = seloutB[AW-1:0];
  assign cnst_word_a = {cnst_half(seloutA[3:2]), cnst_half(seloutA[1:0])};
  assign cnst_word_b = {cnst_half(seloutB[3:2]), cnst_half(seloutB[1:0])};

  always_comb begin
    rd_a = mem[idx_a];
    rd_b = mem[idx_b];
`ifdef REG_BANK_BYPASS_EN
    if (regwen && (idx_a == selwreg)) rd_a = wr_word;
    if (regwen && (idx_b == selwreg)) rd_b = wr_word;
`endif
  end

  // Constant loads work during a clear; entry reads are blocked until it finishes.
  always_ff @(posedge clock) begin
    if (reset) begin
      outA <= '0;
      outB <= '0;
    end else begin
      if (enrregA) begin
        if (cnstA)      outA <= cnst_word_a;
        else if (!busy) outA <= rd_a;
      end
      if (enrregB) begin
        if (cnstB)      outB <= cnst_word_b;
        else if (!busy) outB <= rd_b;
      end
    end
  end

endmodule
